// File: rtl/ika87ad_sim_pkg.sv
// ika87ad_sim_pkg: shared constants and types for the IKA87AD bus companion
package ika87ad_sim_pkg;
  localparam logic [2:0]  IRQ_POL_DEF  = 3'b010;
  localparam logic [15:0] IRQ_ADDR_DEF = 16'hFF00;
  localparam int IRQ_NMI  = 0;
  localparam int IRQ_INT1 = 1;
  localparam int IRQ_INT2 = 2;
  typedef enum logic {WS_IDLE, WS_PEND} wr_state_t;
endpackage

// File: rtl/ika87ad_busmem_if.sv
// ika87ad_busmem_if: CPU external bus (address, strobes, write data, read data/drive)
// master = CPU side, slave = memory side
interface ika87ad_busmem_if;
  logic [15:0] i_A;
  logic        i_RD_n;
  logic        i_WR_n;
  logic [7:0]  i_DO;
  logic [7:0]  o_DI;
  logic        o_DI_OE;
  modport master (output i_A, i_RD_n, i_WR_n, i_DO, input o_DI, o_DI_OE);
  modport slave  (input i_A, i_RD_n, i_WR_n, i_DO, output o_DI, o_DI_OE);
endinterface

// File: rtl/ika87ad_irq_pulse.sv
// ika87ad_irq_pulse: one interrupt channel, PULSE_LEN PCEN ticks long, polarity POL
// in: i_clk, i_rst_n (async low), i_load (restart pulse), i_pcen (tick)
// out: o_active (pulse running), o_irq (line level)
module ika87ad_irq_pulse #(
  parameter logic [7:0] PULSE_LEN = 8'd100,
  parameter bit         POL       = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_pcen,
  output logic o_active,
  output logic o_irq
);
  logic [7:0] r_cnt;
  logic [7:0] w_next;
  // a load overrides a same-cycle tick so a retrigger never shortens the pulse
  always_comb w_next = i_load ? PULSE_LEN : (i_pcen && r_cnt != 8'd0) ? r_cnt - 8'd1 : r_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_cnt    <= 8'd0;
      o_active <= 1'b0;
      o_irq    <= ~POL;
    end else begin
      r_cnt    <= w_next;
      o_active <= w_next != 8'd0;
      o_irq    <= (w_next != 8'd0) ? POL : ~POL;
    end
endmodule

// File: rtl/ika87ad_busmem.sv
// ika87ad_busmem: PCEN prescaler, byte memory on RD_n/WR_n, memory-mapped IRQ pulse port
// in: i_EMUCLK, i_RESET_n (async low), bus (slave: A, RD_n, WR_n, DO -> DI, DI_OE)
// out: o_PCEN clock enable, o_IRQ interrupt lines, o_WRCNT committed-write count
module ika87ad_busmem
  import ika87ad_sim_pkg::*;
#(
  parameter int              AW        = 9,
  parameter int              DIV       = 4,
  parameter int              NIRQ      = 3,
  parameter logic [NIRQ-1:0] IRQ_POL   = NIRQ'(IRQ_POL_DEF),
  parameter logic [15:0]     IRQ_ADDR  = IRQ_ADDR_DEF,
  parameter logic [7:0]      PULSE_LEN = 8'd100,
  parameter string           INIT_FILE = ""
) (
  input  logic             i_EMUCLK,
  input  logic             i_RESET_n,
  ika87ad_busmem_if.slave  bus,
  output logic             o_PCEN,
  output logic [NIRQ-1:0]  o_IRQ,
  output logic [15:0]      o_WRCNT
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0]   r_div;
  logic [7:0]      r_mem [2**AW];
  wr_state_t       r_state;
  logic [15:0]     r_addr;
  logic [7:0]      r_data;
  logic            w_commit;
  logic            w_irq_hit;
  logic [NIRQ-1:0] w_load;
  logic [NIRQ-1:0] w_active;
  logic [7:0]      w_rdata;
  always_ff @(posedge i_EMUCLK or negedge i_RESET_n)
    if (!i_RESET_n) begin
      r_div  <= '0;
      o_PCEN <= 1'b0;
    end else begin
      r_div  <= (r_div == CW'(DIV - 1)) ? '0 : r_div + CW'(1);
      o_PCEN <= r_div == CW'(DIV - 1);
    end
  // commit fires on the first cycle WR_n is seen high after a low strobe
  assign w_commit  = (r_state == WS_PEND) && bus.i_WR_n;
  assign w_irq_hit = r_addr == IRQ_ADDR;
  assign w_load    = (w_commit && w_irq_hit) ? r_data[NIRQ-1:0] : '0;
  always_ff @(posedge i_EMUCLK or negedge i_RESET_n)
    if (!i_RESET_n) begin
      r_state <= WS_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      o_WRCNT <= '0;
    end else if (!bus.i_WR_n) begin
      r_state <= WS_PEND;
      r_addr  <= bus.i_A;
      r_data  <= bus.i_DO;
    end else if (r_state == WS_PEND) begin
      r_state <= WS_IDLE;
      o_WRCNT <= o_WRCNT + 16'd1;
    end
  always_ff @(posedge i_EMUCLK)
    if (w_commit && !w_irq_hit) r_mem[r_addr[AW-1:0]] <= r_data;
  assign w_rdata = (bus.i_A == IRQ_ADDR) ? 8'(w_active) : r_mem[bus.i_A[AW-1:0]];
  always_ff @(posedge i_EMUCLK or negedge i_RESET_n)
    if (!i_RESET_n) begin
      bus.o_DI    <= 8'd0;
      bus.o_DI_OE <= 1'b0;
    end else begin
      bus.o_DI    <= w_rdata;
      bus.o_DI_OE <= ~bus.i_RD_n & bus.i_WR_n;
    end
  for (genvar i = 0; i < NIRQ; i++) begin : g_irq
    ika87ad_irq_pulse #(.PULSE_LEN(PULSE_LEN), .POL(IRQ_POL[i])) u_pulse (
      .i_clk    (i_EMUCLK),
      .i_rst_n  (i_RESET_n),
      .i_load   (w_load[i]),
      .i_pcen   (o_PCEN),
      .o_active (w_active[i]),
      .o_irq    (o_IRQ[i])
    );
  end
endmodule
